fifo_rd_packer: RTL and testbench

- Read-side consumer of the async FIFO, running in the FIFO read-clock domain.
- Pops bytes from the FIFO read port and packs them into LANES-byte words.
- Presents each word on a valid/ready master stream with a per-byte keep mask.
- A flush request emits a partial word, so downstream logic never waits on a half-filled word.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/pack_outreg.sv | 50 +++++
 rtl/fifo_rd_packer.sv | 131 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the async FIFO and its read-side packer.
// Holds default widths, the byte type and the packer FSM states.
package fifo_pkg;

  localparam int DFLT_DATA_WIDTH = 8;
  localparam int DFLT_ADDR_SIZE  = 4;

  typedef logic [DFLT_DATA_WIDTH-1:0] byte_t;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } rd_state_e;

endpackage

// File: rtl/pack_outreg.sv
// Output word register for the FIFO read packer.
// Ports: load/load_data/load_keep capture a word; m_* is the
// valid/ready master stream; word_count counts accepted words;
// out_free reports that a load may happen at the next edge.
module pack_outreg #(
  parameter int WORD_W    = 32,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_W-1:0]    load_data,
  input  logic [LANES-1:0]     load_keep,
  input  logic                 m_ready,
  output logic [WORD_W-1:0]    m_data,
  output logic [LANES-1:0]     m_keep,
  output logic                 m_valid,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 out_free
);

  logic xfer;

  assign xfer     = m_valid & m_ready;
  assign out_free = ~m_valid | m_ready;

  // load is only raised while out_free, so a held word is
  // never overwritten before it is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
      word_count <= '0;
    end else begin
      if (xfer) begin
        word_count <= word_count + 1'b1;
      end
      if (load) begin
        m_data  <= load_data;
        m_keep  <= load_keep;
        m_valid <= 1'b1;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer packing LANES bytes per output word.
// Ports: fifo_out/fifo_empty/fifo_r_en talk to the FWFT FIFO;
// flush emits a partial word; m_data/m_keep/m_valid/m_ready form
// the output stream; busy and word_count report status.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = fifo_pkg::DFLT_DATA_WIDTH,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       fifo_out,
  input  logic                        fifo_empty,
  output logic                        fifo_r_en,
  input  logic                        flush,
  output logic [DATA_WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]            m_keep,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        word_count
);

  import fifo_pkg::*;

  localparam int CW = $clog2(LANES) + 1;
  localparam int IW = CW - 1;
  localparam int WW = DATA_WIDTH * LANES;
  localparam logic [CW-1:0] FULL = CW'(LANES);

  rd_state_e             state_q;
  rd_state_e             state_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [CW-1:0]         fill;
  logic [DATA_WIDTH-1:0] acc_q [LANES];
  logic [WW-1:0]         word;
  logic [LANES-1:0]      keep;
  logic                  pop;
  logic                  load;
  logic                  out_free;

  assign pop = rst & ~fifo_empty & (cnt_q < FULL)
             & (state_q == FILL);
  assign fifo_r_en = pop;

  // Byte count including a byte popped this cycle.
  assign fill = cnt_q + {{IW{1'b0}}, pop};

  assign busy = (cnt_q != '0) | (state_q == FLUSH);

  // Candidate output word: stored lanes plus the byte being
  // popped now, so a completing pop loads at the same edge.
  always_comb begin
    word = '0;
    keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < fill) begin
        keep[i] = 1'b1;
        if (pop && cnt_q[IW-1:0] == IW'(i)) begin
          word[i*DATA_WIDTH +: DATA_WIDTH] = fifo_out;
        end else begin
          word[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
        end
      end
    end
  end

  // A flush that coincides with a full-word load has nothing
  // left to emit, so it is dropped rather than entering FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = fill;
    load    = 1'b0;
    unique case (state_q)
      FILL: begin
        if (fill == FULL && out_free) begin
          load  = 1'b1;
          cnt_d = '0;
        end else if (flush && fill != '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        acc_q[cnt_q[IW-1:0]] <= fifo_out;
      end
    end
  end

  pack_outreg #(
    .WORD_W    (WW),
    .LANES     (LANES),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (word),
    .load_keep  (keep),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .word_count (word_count),
    .out_free   (out_free)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer.
// FIFO model, word scoreboard, vector table and corner sequences.
module tb_fifo_rd_packer;

  import fifo_pkg::*;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  byte_t            fifo_out;
  logic             fifo_empty;
  logic             fifo_r_en;
  logic             flush;
  logic [31:0]      m_data;
  logic [3:0]       m_keep;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic [CNT_W-1:0] word_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_wc = 0;

  byte_t       fq[$];
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  logic        pend;

  typedef struct {
    logic [31:0] din;
    int          n;
    bit          fl;
    logic [31:0] ed;
    logic [3:0]  ek;
  } vec_t;

  vec_t tbl[6];

  fifo_rd_packer #(
    .DATA_WIDTH (8),
    .LANES      (4),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h/%0h want none",
                 m_keep, m_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word", {28'd0, m_keep, m_data}, {28'd0, mon_e});
      end
    end
  end

  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_out   = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic step();
    @(negedge clk);
    pend = fifo_r_en;
    @(posedge clk);
    #1;
    if (pend && fq.size() != 0) begin
      void'(fq.pop_front());
    end
    upd_fifo();
  endtask

  task automatic push_bytes(logic [31:0] d, int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(d[8*i +: 8]);
    end
    upd_fifo();
  endtask

  task automatic expect_word(logic [31:0] d, logic [3:0] k);
    exp_q.push_back({k, d});
    exp_wc++;
  endtask

  task automatic wait_drain(int budget, string name);
    int c = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && c < budget) begin
      step();
      c++;
    end
    if (exp_q.size() != 0 || fq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d words left want 0",
               name, exp_q.size());
      exp_q.delete();
      fq.delete();
      upd_fifo();
    end
  endtask

  task automatic wait_fifo_empty(int budget);
    int c = 0;
    while (fq.size() != 0 && c < budget) begin
      step();
      c++;
    end
  endtask

  initial begin
    logic [31:0] w;
    int nw;

    tbl[0] = '{32'h00C3B2A1, 3, 1'b1, 32'h00C3B2A1, 4'b0111};
    tbl[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 4'b0011};
    tbl[2] = '{32'h000000E7, 1, 1'b1, 32'h000000E7, 4'b0001};
    tbl[3] = '{32'h78563412, 4, 1'b1, 32'h78563412, 4'b1111};
    tbl[4] = '{32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF, 4'b1111};
    tbl[5] = '{32'h00CC0000, 3, 1'b1, 32'h00CC0000, 4'b0111};

    rst     = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    pend    = 1'b0;
    fq.push_back(8'h55);
    upd_fifo();

    // reset with a non-empty FIFO
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_ren", pend, 0);
      chk("rst_out", {m_valid, m_keep, m_data, word_count}, 0);
      chk("rst_busy", busy, 0);
    end
    fq.delete();
    upd_fifo();
    rst = 1'b1;

    // streaming, one byte per cycle
    push_bytes(32'h44332211, 4);
    push_bytes(32'h88776655, 4);
    expect_word(32'h44332211, 4'hF);
    expect_word(32'h88776655, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stream_ren", pend, 1);
      chk("stream_valid", m_valid, (k == 4 || k == 8) ? 1 : 0);
    end
    wait_drain(20, "stream");
    chk("stream_wc", word_count, exp_wc % (1 << CNT_W));

    // backpressure
    m_ready = 1'b0;
    push_bytes(32'hD4C3B2A1, 4);
    push_bytes(32'h5A6B7C8D, 4);
    expect_word(32'hD4C3B2A1, 4'hF);
    expect_word(32'h5A6B7C8D, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 4) begin
        chk("bp_hold", {m_valid, m_keep, m_data},
            {1'b1, 4'hF, 32'hD4C3B2A1});
      end
    end
    chk("bp_ren", pend, 0);
    chk("bp_busy", busy, 1);
    m_ready = 1'b1;
    wait_drain(20, "bp");
    chk("bp_wc", word_count, exp_wc % (1 << CNT_W));

    // vector table
    foreach (tbl[i]) begin
      expect_word(tbl[i].ed, tbl[i].ek);
      push_bytes(tbl[i].din, tbl[i].n);
      wait_fifo_empty(20);
      if (tbl[i].fl) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      wait_drain(20, "vec");
      step();
      chk("vec_idle", {busy, m_valid}, 0);
    end

    // flush with nothing held
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_idle", {busy, m_valid}, 0);
    end
    chk("flush_idle_wc", word_count, exp_wc % (1 << CNT_W));

    // flush in the same cycle as the first pop
    push_bytes(32'h0000005A, 1);
    expect_word(32'h0000005A, 4'b0001);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_pop_ren", pend, 1);
    chk("flush_pop_busy", busy, 1);
    wait_drain(20, "flush_pop");
    step();
    chk("flush_pop_idle", {busy, m_valid}, 0);

    // reset mid-word
    push_bytes(32'h0000FFEE, 2);
    step();
    step();
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_wc = 0;
    chk("mid_rst", {busy, m_valid, word_count}, 0);
    push_bytes(32'h11223344, 4);
    expect_word(32'h11223344, 4'hF);
    wait_drain(20, "mid");
    chk("mid_wc", word_count, 1);

    // word counter wrap
    nw = (1 << CNT_W) - 2;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      push_bytes(w, 4);
      expect_word(w, 4'hF);
    end
    wait_drain(nw * 4 + 50, "wrap");
    chk("wrap_max", word_count, (1 << CNT_W) - 1);
    push_bytes(32'hCAFEF00D, 4);
    expect_word(32'hCAFEF00D, 4'hF);
    wait_drain(20, "wrap");
    chk("wrap_zero", word_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
